uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217: clock cycles per bit period, minimum 2.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, legal 5..9.
REQ-003 Parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1: stop bit periods, legal 1 or 2.
REQ-005 Parameter GAP_BITS, default 1: idle-high bit periods after the stop bits, legal 0..3.
REQ-006 Parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of 2, minimum 2.
REQ-007 i_Clock  in  1  sole clock; all logic on its rising edge.
REQ-008 i_Rst_L  in  1  asynchronous, active-low reset.
REQ-009 i_TX_DV  in  1  write strobe; accepted only when o_TX_Ready=1.
REQ-010 i_TX_Byte  in  DATA_BITS  data to queue.
REQ-011 o_TX_Ready  out  1  FIFO not full.
REQ-012 o_TX_Overrun  out  1  one-cycle pulse when i_TX_DV=1 while o_TX_Ready=0.
REQ-013 o_TX_Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 o_TX_Active  out  1  high from the frame's start bit through its gap.
REQ-015 o_TX_Serial  out  1  registered serial line, idle high.
REQ-016 o_TX_Done  out  1  one-cycle pulse per completed frame.

Function
REQ-017 States: IDLE, START, DATA, PARITY, STOP, GAP; PARITY is skipped when PARITY=0, and GAP is skipped when GAP_BITS=0.
REQ-018 IDLE with FIFO non-empty: pop the head into the shift register and enter START; o_TX_Serial=0 from the next edge.
REQ-019 Every bit period lasts exactly CLKS_PER_BIT cycles; the bit counter resets to 0 on each bit boundary.
REQ-020 DATA sends DATA_BITS bits, LSB first.
REQ-021 Parity bit: XOR of the data bits for even parity, or its inverse for odd parity.
REQ-022 STOP drives 1 for STOP_BITS periods; GAP drives 1 for GAP_BITS periods.
REQ-023 At the end of the last period, pulse o_TX_Done for one cycle and return to IDLE.
REQ-024 o_TX_Active falls in the same cycle that o_TX_Done pulses.
REQ-025 Back-to-back: if the FIFO is non-empty at return to IDLE, the next start bit begins exactly one cycle after the o_TX_Done pulse.
REQ-026 Frame length: CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS+GAP_BITS) cycles, measured from the start-bit edge to the o_TX_Done cycle inclusive.
REQ-027 Full FIFO: a write in the same cycle as a pop is still refused; o_TX_Ready depends only on the registered count.
REQ-028 Refused writes do not alter FIFO contents or count.
REQ-029 Queued bytes are transmitted strictly in FIFO order.
REQ-030 The pointers wrap modulo FIFO_DEPTH; the count distinguishes full from empty.

Reset
REQ-031 While i_Rst_L=0, asynchronously force: state IDLE, FIFO empty, counters 0, o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Overrun=0, o_TX_Ready=1, o_TX_Count=0.
REQ-032 A reset mid-frame abandons the frame, produces no o_TX_Done pulse, and discards all queued data.

Structure
REQ-033 Package uart_pkg holds the state encoding, the parity-mode constants (NONE/EVEN/ODD), and the legal-range checks.
REQ-034 The FIFO is a sub-module, uart_tx_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty).
REQ-035 Illegal parameter values fail elaboration.

Verification (CLKS_PER_BIT=4)
REQ-036 8N1, GAP_BITS=1, write 0x55 -> line 0, then 1,0,1,0,1,0,1,0, then 1,1, each 4 cycles; o_TX_Done at cycle 44.
REQ-037 8E1 with 0x07 -> parity bit 1; 8O1 with 0x07 -> parity bit 0; frame length 48.
REQ-038 DATA_BITS=7, STOP_BITS=2, GAP_BITS=0, write 0x41 -> bits 1,0,0,0,0,0,1, then 2 stop periods; frame length 40.
REQ-039 FIFO_DEPTH=4, write 0x01..0x06 on consecutive cycles -> o_TX_Ready falls and the refused write pulses o_TX_Overrun; accepted bytes are sent in order, each start bit one cycle after the prior o_TX_Done.
REQ-040 Assert i_Rst_L=0 during data bit 3 with 2 bytes queued -> o_TX_Serial=1 and o_TX_Count=0 immediately; no o_TX_Done; line stays idle after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Holds the FSM encoding, the parity-mode constants and the parameter legality checks.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit cfg_legal(input int clks_per_bit, input int data_bits,
                                     input int parity, input int stop_bits,
                                     input int gap_bits, input int fifo_depth);
        return (clks_per_bit >= 2)
            && (data_bits >= 5) && (data_bits <= 9)
            && (parity >= PAR_NONE) && (parity <= PAR_ODD)
            && (stop_bits >= 1) && (stop_bits <= 2)
            && (gap_bits >= 0) && (gap_bits <= 3)
            && is_pow2(fifo_depth);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small transmit FIFO: power-of-two depth, wrapping pointers, occupancy count.
// The head entry is readable combinationally so the transmitter can load it on the pop edge.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a transmit FIFO, optional parity and idle gap.
// The final period of a frame is one cycle shorter in-state; its last cycle is spent in IDLE with o_TX_Done high.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    input  logic                          i_TX_DV,
    input  logic [DATA_BITS-1:0]          i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Overrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_TX_Count,
    output logic                          o_TX_Active,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Done
);
    import uart_pkg::*;

    if (!cfg_legal(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS, GAP_BITS, FIFO_DEPTH)) begin : g_bad_cfg
        $error("uart_tx_cfg: illegal parameter combination");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_FINAL = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0] GAP_LAST  = 4'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);
    localparam logic       ODD_FLIP  = (PARITY == PAR_ODD);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   serial_q, serial_d;
    logic                   active_q, active_d;
    logic                   done_q, done_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   final_period;
    logic                   bit_end;

    assign fifo_push    = i_TX_DV && !fifo_full;
    assign o_TX_Ready   = !fifo_full;
    assign o_TX_Overrun = i_TX_DV && fifo_full;
    assign o_TX_Active  = active_q;
    assign o_TX_Serial  = serial_q;
    assign o_TX_Done    = done_q;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_Clock),
        .rst_n (i_Rst_L),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (i_TX_Byte),
        .dout  (fifo_dout),
        .count (o_TX_Count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign final_period = ((state_q == ST_GAP) && (bit_idx_q == GAP_LAST))
                       || ((state_q == ST_STOP) && (GAP_BITS == 0) && (bit_idx_q == STOP_LAST));
    assign bit_end = (clk_cnt_q == (final_period ? BIT_FINAL : BIT_LAST));

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                serial_d  = 1'b1;
                active_d  = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    parity_d  = (^fifo_dout) ^ ODD_FLIP;
                    serial_d  = 1'b0;
                    active_d  = 1'b1;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    serial_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            serial_d = parity_q;
                            state_d  = ST_PARITY;
                        end else begin
                            serial_d = 1'b1;
                            state_d  = ST_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        serial_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    serial_d  = 1'b1;
                    bit_idx_d = '0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q != STOP_LAST) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else if (GAP_BITS == 0) begin
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (bit_end) begin
                    if (bit_idx_q != GAP_LAST) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else begin
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations at CLKS_PER_BIT=4 driven from a frame table,
// plus hand sequences for FIFO overflow with back-to-back frames and mid-frame reset.
module tb_uart_tx_cfg;

    localparam int CPB = 4;
    localparam int DB [4] = '{8, 8, 8, 7};
    localparam int PB [4] = '{0, 1, 2, 0};
    localparam int SB [4] = '{1, 1, 1, 2};
    localparam int GB [4] = '{1, 1, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dv;
    logic [8:0] byt [4];
    logic [3:0] rdy_w, ovr_w, act_w, ser_w, done_w;
    logic [2:0] cnt_w [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_dut
        uart_tx_cfg #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB[gi]),
            .PARITY       (PB[gi]),
            .STOP_BITS    (SB[gi]),
            .GAP_BITS     (GB[gi]),
            .FIFO_DEPTH   (4)
        ) u_dut (
            .i_Clock      (clk),
            .i_Rst_L      (rst_n),
            .i_TX_DV      (dv[gi]),
            .i_TX_Byte    (byt[gi][DB[gi]-1:0]),
            .o_TX_Ready   (rdy_w[gi]),
            .o_TX_Overrun (ovr_w[gi]),
            .o_TX_Count   (cnt_w[gi]),
            .o_TX_Active  (act_w[gi]),
            .o_TX_Serial  (ser_w[gi]),
            .o_TX_Done    (done_w[gi])
        );
    end

    // bits holds the line level of each bit period, period 0 (start bit) in bit nper-1.
    typedef struct {
        int         dut;
        logic [8:0] data;
        logic [15:0] bits;
        int         nper;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] frame_8n1(input logic [7:0] b);
        logic [15:0] f;
        f = '0;
        f[10] = 1'b0;
        for (int j = 0; j < 8; j++) f[9 - j] = b[j];
        f[1] = 1'b1;
        f[0] = 1'b1;
        return f;
    endfunction

    // Starts just after the start-bit edge; returns at the negedge of the o_TX_Done cycle.
    task automatic check_frame(input int d, input logic [15:0] bits, input int nper, input string tag);
        int len;
        int p;
        len = nper * CPB;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            p = (k - 1) / CPB;
            chk($sformatf("%s serial c%0d", tag, k), int'(ser_w[d]), int'(bits[nper - 1 - p]));
            chk($sformatf("%s done c%0d", tag, k), int'(done_w[d]), (k == len) ? 1 : 0);
            chk($sformatf("%s active c%0d", tag, k), int'(act_w[d]), (k == len) ? 0 : 1);
        end
    endtask

    task automatic send_one(input int d, input logic [8:0] data, input string tag);
        @(posedge clk); #1;
        dv[d]  = 1'b1;
        byt[d] = data;
        @(posedge clk); #1;
        dv[d]  = 1'b0;
        @(negedge clk);
        chk($sformatf("%s queued count", tag), int'(cnt_w[d]), 1);
        chk($sformatf("%s line idle before start", tag), int'(ser_w[d]), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 9'h055, 16'b01010101011, 11};
        vecs[1] = '{1, 9'h007, 16'b011100000111, 12};
        vecs[2] = '{2, 9'h007, 16'b011100000011, 12};
        vecs[3] = '{3, 9'h041, 16'b0100000111, 10};
        vecs[4] = '{0, 9'h0A3, 16'b01100010111, 11};
        vecs[5] = '{1, 9'h000, 16'b000000000011, 12};
        vecs[6] = '{2, 9'h0FF, 16'b011111111111, 12};
        vecs[7] = '{3, 9'h07F, 16'b0111111111, 10};

        rst_n = 1'b1;
        dv    = '0;
        for (int i = 0; i < 4; i++) byt[i] = '0;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset serial d%0d", d), int'(ser_w[d]), 1);
            chk($sformatf("reset ready d%0d", d), int'(rdy_w[d]), 1);
            chk($sformatf("reset count d%0d", d), int'(cnt_w[d]), 0);
            chk($sformatf("reset active d%0d", d), int'(act_w[d]), 0);
            chk($sformatf("reset done d%0d", d), int'(done_w[d]), 0);
            chk($sformatf("reset overrun d%0d", d), int'(ovr_w[d]), 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            send_one(vecs[i].dut, vecs[i].data, tag);
            check_frame(vecs[i].dut, vecs[i].bits, vecs[i].nper, tag);
            @(negedge clk);
            chk($sformatf("%s idle serial after", tag), int'(ser_w[vecs[i].dut]), 1);
            chk($sformatf("%s done cleared", tag), int'(done_w[vecs[i].dut]), 0);
            chk($sformatf("%s fifo empty", tag), int'(cnt_w[vecs[i].dut]), 0);
        end

        // Overflow: six consecutive writes, the sixth is refused; five frames back-to-back.
        @(posedge clk); #1;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    dv[0]  = 1'b1;
                    byt[0] = 9'(i);
                    if (i == 5) begin
                        @(negedge clk);
                        chk("ovf ready before full", int'(rdy_w[0]), 1);
                        chk("ovf count before full", int'(cnt_w[0]), 3);
                        chk("ovf no overrun before full", int'(ovr_w[0]), 0);
                    end else if (i == 6) begin
                        @(negedge clk);
                        chk("ovf ready when full", int'(rdy_w[0]), 0);
                        chk("ovf overrun pulse", int'(ovr_w[0]), 1);
                        chk("ovf count when full", int'(cnt_w[0]), 4);
                    end
                    @(posedge clk); #1;
                end
                dv[0] = 1'b0;
                @(negedge clk);
                chk("ovf overrun cleared", int'(ovr_w[0]), 0);
                chk("ovf count unchanged by refused write", int'(cnt_w[0]), 4);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                for (int b = 1; b <= 5; b++) begin
                    check_frame(0, frame_8n1(8'(b)), 11, $sformatf("ovf byte%0d", b));
                end
                @(negedge clk);
                chk("ovf no sixth frame", int'(ser_w[0]), 1);
                chk("ovf fifo drained", int'(cnt_w[0]), 0);
            end
        join

        // Mid-frame reset during data bit 3 with two bytes still queued.
        @(posedge clk); #1;
        dv[0]  = 1'b1;
        byt[0] = 9'h000;
        @(posedge clk); #1;
        byt[0] = 9'h011;
        @(posedge clk); #1;
        byt[0] = 9'h022;
        @(posedge clk); #1;
        dv[0]  = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        chk("rst data bit3 low", int'(ser_w[0]), 0);
        chk("rst two queued", int'(cnt_w[0]), 2);
        chk("rst active mid frame", int'(act_w[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("rst serial forced high", int'(ser_w[0]), 1);
        chk("rst count cleared", int'(cnt_w[0]), 0);
        chk("rst ready", int'(rdy_w[0]), 1);
        chk("rst active cleared", int'(act_w[0]), 0);
        chk("rst done low", int'(done_w[0]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst serial c%0d", k), int'(ser_w[0]), 1);
            chk($sformatf("post-rst done c%0d", k), int'(done_w[0]), 0);
        end
        chk("post-rst count", int'(cnt_w[0]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
